// File: rtl/awg_sweep_pkg.sv
// ---------------------------------------------------------------------------
// awg_sweep_pkg
//   Shared types and constants for the AWG frequency-sweep controller.
//   - state_e   : sweep controller states (IDLE, UP, DOWN, HOLD)
//   - MODE_SAW  : sawtooth sweep (restart at start bound)
//   - MODE_TRI  : triangle sweep (up/down)
//   - FTW_W_DEF / ADDR_W_DEF : default tuning-word and LUT-address widths
// ---------------------------------------------------------------------------
package awg_sweep_pkg;

    localparam int unsigned FTW_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 10;

    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/awg_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// awg_sweep_ctrl_if
//   Control/status bundle of the AWG sweep controller.
//   Inputs to the controller : tick, en, mode, start_ftw, stop_ftw, step_ftw
//   Outputs of the controller: ftw, phase_addr, dir, sweep_done, cfg_err
//   modport master : the side driving tick/config (timer + register block)
//   modport slave  : the sweep controller itself
// ---------------------------------------------------------------------------
interface awg_sweep_ctrl_if
    import awg_sweep_pkg::*;
#(
    parameter int unsigned FTW_W  = FTW_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              tick;
    logic              en;
    logic              mode;
    logic [FTW_W-1:0]  start_ftw;
    logic [FTW_W-1:0]  stop_ftw;
    logic [FTW_W-1:0]  step_ftw;
    logic [FTW_W-1:0]  ftw;
    logic [ADDR_W-1:0] phase_addr;
    logic              dir;
    logic              sweep_done;
    logic              cfg_err;

    modport master (
        output tick, en, mode, start_ftw, stop_ftw, step_ftw,
        input  ftw, phase_addr, dir, sweep_done, cfg_err
    );

    modport slave (
        input  tick, en, mode, start_ftw, stop_ftw, step_ftw,
        output ftw, phase_addr, dir, sweep_done, cfg_err
    );

endinterface

// File: rtl/awg_phase_acc.sv
// ---------------------------------------------------------------------------
// awg_phase_acc
//   DDS phase accumulator. Adds ftw_i every enabled clock (natural modulo
//   2^FTW_W wrap) and exposes the top ADDR_W phase bits as LUT address.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : force phase to 0 (takes priority over en_i)
//   en_i       : accumulate this cycle
//   ftw_i      : frequency tuning word
//   addr_o     : phase[FTW_W-1 -: ADDR_W]
// ---------------------------------------------------------------------------
module awg_phase_acc
    import awg_sweep_pkg::*;
#(
    parameter int unsigned FTW_W  = FTW_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [FTW_W-1:0]  ftw_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [FTW_W-1:0] phase_q;
    logic [FTW_W-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = phase_q + ftw_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign addr_o = phase_q[FTW_W-1 -: ADDR_W];

endmodule

// File: rtl/awg_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// awg_sweep_ctrl
//   Frequency-sweep controller + DDS phase accumulator. On each tick the
//   tuning word steps between start and stop (sawtooth or triangle); every
//   clock the phase accumulator advances by the current tuning word.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : awg_sweep_ctrl_if.slave (tick/en/mode/start/stop/step in;
//           ftw/phase_addr/dir/sweep_done/cfg_err out)
//   Optional build macro AWG_SWEEP_TICK_SYNC_EN: tick passes through a
//   2-flop synchronizer and rising-edge detect (3-cycle tick-to-ftw);
//   otherwise tick is used directly (1-cycle tick-to-ftw).
// ---------------------------------------------------------------------------
module awg_sweep_ctrl
    import awg_sweep_pkg::*;
#(
    parameter int unsigned FTW_W  = FTW_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    awg_sweep_ctrl_if.slave        bus
);

    state_e           state_q, state_d;
    logic [FTW_W-1:0] ftw_q, ftw_d;
    logic [FTW_W-1:0] start_l_q, start_l_d;
    logic [FTW_W-1:0] stop_l_q, stop_l_d;
    logic [FTW_W-1:0] step_l_q, step_l_d;
    logic             mode_l_q, mode_l_d;
    logic             sweep_done_q, sweep_done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             step_pulse;

`ifdef AWG_SWEEP_TICK_SYNC_EN
    logic tick_s1_q, tick_s2_q, tick_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_prev_q <= 1'b0;
        end else begin
            tick_s1_q   <= bus.tick;
            tick_s2_q   <= tick_s1_q;
            tick_prev_q <= tick_s2_q;
        end
    end

    assign step_pulse = tick_s2_q & ~tick_prev_q;
`else
    assign step_pulse = bus.tick;
`endif

    // Sums/differences carry one extra bit so overflow/underflow saturates.
    logic [FTW_W:0] up_sum;
    logic [FTW_W:0] dn_diff;
    logic [FTW_W:0] start_sum;
    logic [FTW_W-1:0] up_sat;
    logic [FTW_W-1:0] dn_sat;
    logic [FTW_W-1:0] start_up_sat;

    always_comb begin
        up_sum    = {1'b0, ftw_q} + {1'b0, step_l_q};
        dn_diff   = {1'b0, ftw_q} - {1'b0, step_l_q};
        start_sum = {1'b0, start_l_q} + {1'b0, step_l_q};
        up_sat       = (up_sum > {1'b0, stop_l_q}) ? stop_l_q : up_sum[FTW_W-1:0];
        dn_sat       = (dn_diff[FTW_W] || (dn_diff[FTW_W-1:0] < start_l_q))
                       ? start_l_q : dn_diff[FTW_W-1:0];
        start_up_sat = (start_sum > {1'b0, stop_l_q}) ? stop_l_q : start_sum[FTW_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        ftw_d        = ftw_q;
        start_l_d    = start_l_q;
        stop_l_d     = stop_l_q;
        step_l_d     = step_l_q;
        mode_l_d     = mode_l_q;
        sweep_done_d = 1'b0;
        cfg_err_d    = cfg_err_q;

        if (!bus.en) begin
            // Disable wins over any tick in the same cycle.
            state_d   = ST_IDLE;
            ftw_d     = '0;
            cfg_err_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    start_l_d = bus.start_ftw;
                    stop_l_d  = bus.stop_ftw;
                    step_l_d  = bus.step_ftw;
                    mode_l_d  = bus.mode;
                    ftw_d     = bus.start_ftw;
                    if ((bus.start_ftw > bus.stop_ftw) || (bus.step_ftw == '0)) begin
                        state_d   = ST_HOLD;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d   = ST_UP;
                        cfg_err_d = 1'b0;
                    end
                end
                ST_UP: begin
                    if (step_pulse) begin
                        if (ftw_q == stop_l_q) begin
                            if (mode_l_q == MODE_SAW) begin
                                ftw_d        = start_l_q;
                                sweep_done_d = ~sweep_done_q;
                            end else begin
                                state_d = ST_DOWN;
                                ftw_d   = dn_sat;
                            end
                        end else begin
                            ftw_d = up_sat;
                        end
                    end
                end
                ST_DOWN: begin
                    if (step_pulse) begin
                        if (ftw_q == start_l_q) begin
                            state_d      = ST_UP;
                            ftw_d        = start_up_sat;
                            sweep_done_d = ~sweep_done_q;
                        end else begin
                            ftw_d = dn_sat;
                        end
                    end
                end
                ST_HOLD: begin
                    ftw_d     = start_l_q;
                    cfg_err_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    ftw_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ftw_q        <= '0;
            start_l_q    <= '0;
            stop_l_q     <= '0;
            step_l_q     <= '0;
            mode_l_q     <= 1'b0;
            sweep_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ftw_q        <= ftw_d;
            start_l_q    <= start_l_d;
            stop_l_q     <= stop_l_d;
            step_l_q     <= step_l_d;
            mode_l_q     <= mode_l_d;
            sweep_done_q <= sweep_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    awg_phase_acc #(
        .FTW_W  (FTW_W),
        .ADDR_W (ADDR_W)
    ) u_phase_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q != ST_IDLE),
        .ftw_i  (ftw_q),
        .addr_o (bus.phase_addr)
    );

    assign bus.ftw        = ftw_q;
    assign bus.dir        = (state_q == ST_DOWN);
    assign bus.sweep_done = sweep_done_q;
    assign bus.cfg_err    = cfg_err_q;

endmodule
